// File: rtl/axis_nibble_packer.sv
// Packs RATIO consecutive IN_W-bit stream beats into one registered output word.
// Optional feature macro PACKER_LAST_EN: tlast_i flushes a partial word and sets tkeep_o/tlast_o.
module axis_nibble_packer #(
    parameter int IN_W  = 4,
    parameter int RATIO = 4
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    tvalid_i,
    output logic                    tready_o,
    input  logic [IN_W-1:0]         tdata_i,
    input  logic                    tlast_i,
    output logic                    tvalid_o,
    input  logic                    tready_i,
    output logic [IN_W*RATIO-1:0]   tdata_o,
    output logic [RATIO-1:0]        tkeep_o,
    output logic                    tlast_o
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             tvalid_q, tvalid_d;
    logic [OUT_W-1:0] tdata_q, tdata_d;
    logic [RATIO-1:0] tkeep_q, tkeep_d;
    logic             tlast_q, tlast_d;

    logic             last_close, closing, in_hs, out_hs, load;
    logic [OUT_W-1:0] merged;
    logic [RATIO-1:0] lane_mask;

`ifdef PACKER_LAST_EN
    assign last_close = tlast_i;
`else
    logic unused_tlast;
    assign last_close   = 1'b0;
    assign unused_tlast = tlast_i;
`endif

    // A closing beat only needs room in the output slot; other beats never stall.
    assign closing  = (cnt_q == CW'(RATIO - 1)) || last_close;
    assign tready_o = arstn_i && (!closing || !tvalid_q || tready_i);
    assign in_hs    = tvalid_i && tready_o;
    assign out_hs   = tvalid_q && tready_i;
    assign load     = in_hs && closing;

    always_comb begin
        merged = (state_q == IDLE) ? '0 : acc_q;
        merged[int'(cnt_q)*IN_W +: IN_W] = tdata_i;
        for (int l = 0; l < RATIO; l++) begin
            lane_mask[l] = (CW'(l) <= cnt_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (in_hs) begin
            if (closing) begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end else begin
                state_d = ACCUM;
                cnt_d   = cnt_q + 1'b1;
                acc_d   = merged;
            end
        end
    end

    // Load wins over drain so a back-to-back word keeps tvalid_o high.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = merged;
            tkeep_d  = lane_mask;
            tlast_d  = last_close;
        end else if (out_hs) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tvalid_o = tvalid_q;
    assign tdata_o  = tdata_q;
    assign tkeep_o  = tkeep_q;
    assign tlast_o  = tlast_q;
endmodule

// File: tb/tb_axis_nibble_packer.sv
// Bench for axis_nibble_packer: cycle vector table plus a word scoreboard fed by a packing model.
module tb_axis_nibble_packer;
    localparam int IN_W  = 4;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
`ifdef PACKER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             arstn_i;
    logic             tvalid_i, tready_o, tlast_i, tvalid_o, tready_i, tlast_o;
    logic [IN_W-1:0]  tdata_i;
    logic [OUT_W-1:0] tdata_o;
    logic [RATIO-1:0] tkeep_o;

    axis_nibble_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .tvalid_i(tvalid_i), .tready_o(tready_o), .tdata_i(tdata_i), .tlast_i(tlast_i),
        .tvalid_o(tvalid_o), .tready_i(tready_i), .tdata_o(tdata_o), .tkeep_o(tkeep_o),
        .tlast_o(tlast_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } word_t;

    typedef struct {
        logic            v;
        logic [IN_W-1:0] d;
        logic            l;
        logic            rdy;
        logic            e_trdy;
        logic            e_tvo;
        logic [OUT_W-1:0] e_data;
    } vec_t;

    word_t            sb_q[$];
    vec_t             vq[$];
    int               checks = 0;
    int               errors = 0;
    int               words_out = 0;
    logic [OUT_W-1:0] m_acc = '0;
    int               m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_beat(input logic [IN_W-1:0] d, input logic l);
        word_t w;
        m_acc[m_cnt*IN_W +: IN_W] = d;
        if (m_cnt == RATIO - 1 || (LAST_EN && l)) begin
            w.data = m_acc;
            w.keep = RATIO'((1 << (m_cnt + 1)) - 1);
            w.last = LAST_EN ? l : 1'b0;
            sb_q.push_back(w);
            m_acc = '0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic step();
        word_t w;
        @(negedge clk_i);
        if (tvalid_o && tready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_word actual=%0h required=none", tdata_o);
            end else begin
                w = sb_q.pop_front();
                chk("sb_data", 32'(tdata_o), 32'(w.data));
                chk("sb_keep", 32'(tkeep_o), 32'(w.keep));
                chk("sb_last", 32'(tlast_o), 32'(w.last));
                words_out++;
            end
        end
        if (tvalid_i && tready_o) model_beat(tdata_i, tlast_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [IN_W-1:0] d, input logic l);
        tvalid_i = 1'b1;
        tdata_i  = d;
        tlast_i  = l;
        step();
        tvalid_i = 1'b0;
        tlast_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        tvalid_i = 1'b0;
        tlast_i  = 1'b0;
        tready_i = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic addv(input logic v, input logic [IN_W-1:0] d, input logic rdy,
                        input logic e_trdy, input logic e_tvo, input logic [OUT_W-1:0] e_data);
        vec_t x;
        x.v = v; x.d = d; x.l = 1'b0; x.rdy = rdy;
        x.e_trdy = e_trdy; x.e_tvo = e_tvo; x.e_data = e_data;
        vq.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_beats, cyc, rdy_low, w0;

        arstn_i = 1'b0; tvalid_i = 1'b0; tdata_i = '0; tlast_i = 1'b0; tready_i = 1'b1;
        #12;
        chk("rst_tvalid", 32'(tvalid_o), 0);
        chk("rst_tdata", 32'(tdata_o), 0);
        chk("rst_tkeep", 32'(tkeep_o), 0);
        chk("rst_tlast", 32'(tlast_o), 0);
        chk("rst_tready", 32'(tready_o), 0);
        @(posedge clk_i); #1;
        arstn_i = 1'b1;
        #1;
        chk("rdy_after_rst", 32'(tready_o), 1);

        // Full word with tready_i=1, then an 8-beat stall sequence.
        addv(1, 4'h1, 1, 1, 0, 16'h0);
        addv(1, 4'h2, 1, 1, 0, 16'h0);
        addv(1, 4'h3, 1, 1, 0, 16'h0);
        addv(1, 4'h4, 1, 1, 0, 16'h0);
        addv(0, 4'h0, 1, 1, 1, 16'h4321);
        addv(0, 4'h0, 1, 1, 0, 16'h0);
        addv(1, 4'h1, 0, 1, 0, 16'h0);
        addv(1, 4'h2, 0, 1, 0, 16'h0);
        addv(1, 4'h3, 0, 1, 0, 16'h0);
        addv(1, 4'h4, 0, 1, 0, 16'h0);
        addv(1, 4'h5, 0, 1, 1, 16'h4321);
        addv(1, 4'h6, 0, 1, 1, 16'h4321);
        addv(1, 4'h7, 0, 1, 1, 16'h4321);
        addv(1, 4'h8, 0, 0, 1, 16'h4321);
        addv(1, 4'h8, 0, 0, 1, 16'h4321);
        addv(1, 4'h8, 1, 1, 1, 16'h4321);
        addv(0, 4'h0, 1, 1, 1, 16'h8765);
        addv(0, 4'h0, 1, 1, 0, 16'h0);

        for (int i = 0; i < vq.size(); i++) begin
            tvalid_i = vq[i].v; tdata_i = vq[i].d; tlast_i = vq[i].l; tready_i = vq[i].rdy;
            #1;
            chk($sformatf("vec%0d_tready", i), 32'(tready_o), 32'(vq[i].e_trdy));
            chk($sformatf("vec%0d_tvalid", i), 32'(tvalid_o), 32'(vq[i].e_tvo));
            if (vq[i].e_tvo) begin
                chk($sformatf("vec%0d_tdata", i), 32'(tdata_o), 32'(vq[i].e_data));
                chk($sformatf("vec%0d_tkeep", i), 32'(tkeep_o), 32'hF);
            end
            step();
        end
        idle(2);

`ifdef PACKER_LAST_EN
        beat(4'hA, 1'b0);
        beat(4'hB, 1'b1);
        chk("last_tvalid", 32'(tvalid_o), 1);
        chk("last_tdata", 32'(tdata_o), 32'h00BA);
        chk("last_tkeep", 32'(tkeep_o), 32'h3);
        chk("last_tlast", 32'(tlast_o), 1);
        idle(1);
        beat(4'h5, 1'b1);
        chk("single_tdata", 32'(tdata_o), 32'h0005);
        chk("single_tkeep", 32'(tkeep_o), 32'h1);
        chk("single_tlast", 32'(tlast_o), 1);
        idle(2);
`else
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b1);
        chk("nolast_no_partial", 32'(tvalid_o), 0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        chk("nolast_tvalid", 32'(tvalid_o), 1);
        chk("nolast_tdata", 32'(tdata_o), 32'h4321);
        chk("nolast_tkeep", 32'(tkeep_o), 32'hF);
        chk("nolast_tlast", 32'(tlast_o), 0);
        idle(2);
`endif

        // Random tvalid_i with the consumer always ready.
        acc_beats = 0; cyc = 0; rdy_low = 0; w0 = words_out;
        tready_i = 1'b1; tlast_i = 1'b0;
        while (acc_beats < 64 && cyc < 2000) begin
            tvalid_i = 1'($urandom_range(0, 1));
            tdata_i  = IN_W'($urandom);
            #1;
            if (!tready_o) rdy_low++;
            if (tvalid_i && tready_o) acc_beats++;
            step();
            cyc++;
        end
        idle(3);
        chk("rand_beats", 32'(acc_beats), 64);
        chk("rand_words", 32'(words_out - w0), 16);
        chk("rand_rdy_low", 32'(rdy_low), 0);

        // Reset mid-word discards the partial accumulator.
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b0);
        arstn_i = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(tvalid_o), 0);
        chk("midrst_tdata", 32'(tdata_o), 0);
        chk("midrst_tkeep", 32'(tkeep_o), 0);
        chk("midrst_tlast", 32'(tlast_o), 0);
        chk("midrst_tready", 32'(tready_o), 0);
        m_acc = '0; m_cnt = 0; sb_q.delete();
        idle(2);
        arstn_i = 1'b1;
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        beat(4'h5, 1'b0);
        beat(4'h6, 1'b0);
        chk("postrst_tvalid", 32'(tvalid_o), 1);
        chk("postrst_tdata", 32'(tdata_o), 32'h6543);
        idle(3);

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
